rnd_digit_arbiter: RTL
======================

// Module: rnd_digit_arbiter
// PURPOSE
// - Shares one free-running 4-bit pseudo-random source among NREQ game requesters.
// - Requesters use a req/gnt handshake. Arbitration is round-robin.
// - Draws are unbiased by rejection: raw values above MAX_VAL are discarded.
// - A bounded retry count keeps latency fixed; after it, a wrap fallback value is used.
// - Sits between the random source and the game FSMs; one digit is delivered per grant.
// PARAMETERS
// - NREQ      default 4   number of requesters, 2..8
// - MAX_VAL   default 9   largest digit delivered, 7..14 (one wrap subtraction always lands in range)
// - MAX_TRIES default 8   raw samples examined before fallback, 1..15
// PORTS
// - clk          in   1     system clock, all state on posedge
// - reset        in   1     asynchronous, active-high; clears all state immediately
// - rnd_raw      in   4     raw source value, changes every cycle, treated as synchronous
// - req          in   NREQ  level request per requester; held until its gnt bit pulses
// - gnt          out  NREQ  one-hot, 1-cycle pulse to the winning requester
// - digit        out  4     delivered value 0..MAX_VAL; held until the next delivery
// - digit_valid  out  1     1-cycle pulse, coincident with gnt
// - fallback     out  1     1 with digit_valid when the value came from the fallback path; else 0
// - busy         out  1     1 in SAMPLE and GRANT
// BEHAVIOUR
// - Reset values: gnt=0, digit=0, digit_valid=0, fallback=0, busy=0; state=IDLE, tries=0, last=NREQ-1.
// - Reset mid-operation: any draw in progress is lost and no gnt is issued.
// - IDLE:
//   - If req!=0, pick the first set bit searching last+1, last+2, ... (mod NREQ).
//   - Latch the winner index, set tries=0, go to SAMPLE.
//   - Arbitration uses req as it stands in this cycle only.
// - SAMPLE, each cycle:
//   - If req[winner]==0: abort to IDLE. No gnt, last unchanged.
//   - Else if rnd_raw<=MAX_VAL and the sample is accepted: latch digit=rnd_raw, fallback=0, go to GRANT.
//   - Else if tries==MAX_TRIES-1: latch digit=rnd_raw-(MAX_VAL+1) (4-bit), fallback=1, go to GRANT.
//     - If rnd_raw<=MAX_VAL but the sample was rejected (filter), latch digit=rnd_raw instead.
//   - Else tries<=tries+1 and stay in SAMPLE.
// - GRANT (one cycle): gnt[winner]=1, digit_valid=1, last<=winner, then go to IDLE.
//   - The requester should drop req after gnt. A req still high in the next IDLE cycle counts as a new request.
// - Latency: req seen in IDLE at cycle n gives gnt at cycle n+2 at best, and n+1+MAX_TRIES at worst.
// - Simultaneous requests: only the winner is served; the others wait, each served within NREQ grants.
// - Request rising during SAMPLE/GRANT: ignored until the next IDLE.
// - Arithmetic is 4-bit unsigned. tries is 4-bit.
// CONFIGURATION
// - REPEAT_FILTER_EN defined:
//   - A sample equal to the previous delivered digit is rejected (counts as a try).
//   - prev_digit resets to 4'hF, so the first draw never matches.
//   - The fallback path is not filtered.
// - REPEAT_FILTER_EN undefined: repeats are accepted; no prev_digit register.
// TESTING
// - Single req[0]=1, rnd_raw=3 -> gnt=0001 and digit=3 at cycle n+2; fallback=0; busy high 2 cycles.
// - req[0]=1, rnd_raw=12,13,11,5 -> three rejections, then digit=5 on the 4th SAMPLE cycle, fallback=0.
// - MAX_TRIES=8, rnd_raw held at 13 -> after 8 samples digit=3, fallback=1.
// - req=1111 held, rnd_raw=2 -> grants in order 0001,0010,0100,1000,0001; digit=2 each time.
// - Abort: req[1] dropped during SAMPLE with rnd_raw=15 -> no gnt, back to IDLE; next grant still starts search at req[0].
// - Reset asserted during SAMPLE -> all outputs 0 asynchronously; after release req[2] alone is granted first.
// - With REPEAT_FILTER_EN: two draws with rnd_raw=4 then 4,6 -> second delivered digit=6.

Source files
------------

// File: rtl/rnd_digit_arbiter_if.sv
// rtl/rnd_digit_arbiter_if.sv - requester-side bus of the random digit arbiter
interface rnd_digit_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [3:0]      digit;
    logic            digit_valid;
    logic            fallback;
    logic            busy;

    // Requester (game FSM) side
    modport master (
        output req,
        input  gnt,
        input  digit,
        input  digit_valid,
        input  fallback,
        input  busy
    );

    // Arbiter side
    modport slave (
        input  req,
        output gnt,
        output digit,
        output digit_valid,
        output fallback,
        output busy
    );
endinterface

// File: rtl/rnd_digit_arbiter.sv
// rtl/rnd_digit_arbiter.sv - round-robin share of a 4-bit random source with rejection sampling; optional REPEAT_FILTER_EN
module rnd_digit_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_VAL   = 9,
    parameter int MAX_TRIES = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          rnd_raw,
    rnd_digit_arbiter_if.slave  bus
);

    localparam int              IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW:0]     NREQ_W   = (IW+1)'(NREQ);
    localparam logic [IW-1:0]   LAST_IDX = IW'(NREQ - 1);
    localparam logic [3:0]      MAX_V    = 4'(MAX_VAL);
    localparam logic [3:0]      WRAP     = 4'(MAX_VAL + 1);
    localparam logic [3:0]      LAST_TRY = 4'(MAX_TRIES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        GRANT
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   winner_q, winner_d;
    logic [3:0]      tries_q, tries_d;
    logic [3:0]      digit_q, digit_d;
    logic            fb_q, fb_d;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [IW:0]     cand;
    logic            in_range;
    logic            repeat_hit;

`ifdef REPEAT_FILTER_EN
    logic [3:0]      prev_q, prev_d;

    // A sample equal to the last delivered digit is treated as a rejection
    always_comb begin
        repeat_hit = (rnd_raw == prev_q);
    end
`else
    always_comb begin
        repeat_hit = 1'b0;
    end
`endif

    always_comb begin
        in_range = (rnd_raw <= MAX_V);
    end

    // Round-robin search: first set req bit starting just after the last winner
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = {1'b0, last_q} + (IW+1)'(i);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!pick_found && bus.req[cand[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IW-1:0];
            end
        end
    end

    // State register and datapath registers; reset drops any draw in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= LAST_IDX;
            winner_q <= '0;
            tries_q  <= '0;
            digit_q  <= '0;
            fb_q     <= 1'b0;
`ifdef REPEAT_FILTER_EN
            prev_q   <= 4'hF;
`endif
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            winner_q <= winner_d;
            tries_q  <= tries_d;
            digit_q  <= digit_d;
            fb_q     <= fb_d;
`ifdef REPEAT_FILTER_EN
            prev_q   <= prev_d;
`endif
        end
    end

    // Next-state: arbitrate in IDLE, draw with bounded retries in SAMPLE, deliver in GRANT
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        winner_d = winner_q;
        tries_d  = tries_q;
        digit_d  = digit_q;
        fb_d     = fb_q;
`ifdef REPEAT_FILTER_EN
        prev_d   = prev_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    winner_d = pick_idx;
                    tries_d  = '0;
                    state_d  = SAMPLE;
                end
            end
            SAMPLE: begin
                if (!bus.req[winner_q]) begin
                    // Requester withdrew: abandon the draw, pointer untouched
                    state_d = IDLE;
                end else if (in_range && !repeat_hit) begin
                    digit_d = rnd_raw;
                    fb_d    = 1'b0;
                    state_d = GRANT;
                end else if (tries_q == LAST_TRY) begin
                    // Out of retries: one wrap subtraction always lands in 0..MAX_VAL;
                    // an in-range value rejected only as a repeat is used as is
                    digit_d = in_range ? rnd_raw : (rnd_raw - WRAP);
                    fb_d    = 1'b1;
                    state_d = GRANT;
                end else begin
                    tries_d = tries_q + 4'd1;
                end
            end
            GRANT: begin
                last_d  = winner_q;
                state_d = IDLE;
`ifdef REPEAT_FILTER_EN
                prev_d  = digit_q;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode from state so reset clears them without waiting for a clock
    always_comb begin
        bus.gnt = '0;
        if (state_q == GRANT) begin
            bus.gnt[winner_q] = 1'b1;
        end
    end

    assign bus.digit       = digit_q;
    assign bus.digit_valid = (state_q == GRANT);
    assign bus.fallback    = (state_q == GRANT) && fb_q;
    assign bus.busy        = (state_q != IDLE);

endmodule
